// File: rtl/rv32i_types_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types_pkg
// Shared types and constants for the RV32I pipelined core.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical no-op (addi x0, x0, 0), shown to decode when idle
//   fetch_entry_t : one buffered fetch result {instruction word, its address}
// -----------------------------------------------------------------------------
package rv32i_types_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage : rv32i_types_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t with single-cycle flush. It sits between
// instruction memory and decode. The head entry is read combinationally.
// Ports:
//   clk, async_rst : clock (rising edge), asynchronous active-high reset
//   push_i         : write push_data_i (ignored when full and not popping)
//   push_data_i    : entry to write
//   pop_i          : remove the head entry (ignored when empty)
//   flush_i        : discard every entry; overrides push and pop
//   full_o/empty_o : occupancy flags
//   count_o        : number of stored entries
//   head_o         : oldest entry (undefined contents when empty)
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
    import rv32i_types_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             async_rst,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Writing while full is legal only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || pop_i);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; count_q alone decides
    // which slots are meaningful, and leaving the RAM unreset keeps it mappable
    // to plain flops or RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule : fetch_fifo

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the RV32I pipeline. Owns the architectural fetch
// PC, issues word requests to instruction memory, buffers in-order responses
// in a small FIFO and hands them to decode with a valid/ready handshake.
// Redirects from execute flush the buffer and discard stale responses.
// Ports:
//   clk, async_rst   : clock (rising edge), asynchronous active-high reset
//   imem_req_valid   : request valid (credit limited, withdrawn on redirect)
//   imem_req_ready   : memory accepts the request
//   imem_req_addr    : word-aligned fetch address
//   imem_rsp_valid   : in-order response, cannot be back-pressured
//   imem_rsp_data    : fetched instruction word
//   redirect_valid   : flush and restart fetch at redirect_addr
//   redirect_addr    : new PC, bits [1:0] forced to zero
//   decode_ready     : decode accepts the presented instruction
//   instr_valid_F    : instruction_F / PC_F valid
//   instruction_F    : FIFO head, NOP_INSTR when empty
//   PC_F             : address of instruction_F, 0 when empty
//   PC_plus4_F       : PC_F + 4 (wraps)
// DATA_WIDTH must equal rv32i_types_pkg::XLEN because fetch_entry_t is fixed.
// -----------------------------------------------------------------------------
module fetch_stage
    import rv32i_types_pkg::fetch_entry_t;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = rv32i_types_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  async_rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_addr,
    input  logic                  decode_ready,
    output logic                  instr_valid_F,
    output logic [DATA_WIDTH-1:0] instruction_F,
    output logic [DATA_WIDTH-1:0] PC_F,
    output logic [DATA_WIDTH-1:0] PC_plus4_F
);

    localparam int                    CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]        DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] WORD_BYTES = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] resp_pc_q,  resp_pc_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;

    logic [DATA_WIDTH-1:0] redirect_pc;
    logic [CNT_W:0]        credits_used;
    logic                  req_fire;
    logic                  rsp_drop;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    fetch_entry_t          fifo_head;
    fetch_entry_t          push_entry;

    assign redirect_pc = redirect_addr & ALIGN_MASK;

    // Credits cover both outstanding requests and buffered entries, so every
    // response that is not dropped is guaranteed a free FIFO slot.
    assign credits_used   = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign imem_req_valid = !async_rst && !redirect_valid && (credits_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response landing in the redirect cycle is stale by definition.
    assign rsp_drop   = redirect_valid || (drop_cnt_q != '0);
    assign fifo_push  = imem_rsp_valid && !rsp_drop;
    assign fifo_pop   = !fifo_empty && decode_ready && !redirect_valid;
    assign push_entry = '{instr: imem_rsp_data, pc: resp_pc_q};

    always_comb begin
        // NOTE: each target is given its hold value first, so no branch can
        // leave it unassigned and infer a latch.
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_cnt_d = drop_cnt_q;
        inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            // Everything still outstanding after this cycle belongs to the old path.
            drop_cnt_d = inflight_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + WORD_BYTES;
            end
            if (fifo_push) begin
                resp_pc_d = resp_pc_q + WORD_BYTES;
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .async_rst   (async_rst),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .flush_i     (redirect_valid),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign instr_valid_F = !fifo_empty;
    assign instruction_F = fifo_empty ? NOP_INSTR : fifo_head.instr;
    assign PC_F          = fifo_empty ? '0 : fifo_head.pc;
    assign PC_plus4_F    = PC_F + WORD_BYTES;

    // Structural invariants of the credit scheme.
    a_drop_le_inflight : assert property (@(posedge clk) disable iff (async_rst)
        drop_cnt_q <= inflight_q);

    a_fifo_no_overflow : assert property (@(posedge clk) disable iff (async_rst)
        !(fifo_push && fifo_full && !fifo_pop));

    a_inflight_no_overflow : assert property (@(posedge clk) disable iff (async_rst)
        !(req_fire && !imem_rsp_valid && (inflight_q == CNT_W'(FIFO_DEPTH))));

    a_no_unexpected_rsp : assert property (@(posedge clk) disable iff (async_rst)
        !(imem_rsp_valid && (inflight_q == '0)));

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A behavioural instruction memory
// (queue of pending requests, data derived from the address) drives the
// response channel. The reference model is the architectural view: requests
// must walk the address space from the last redirect target in steps of 4,
// and decode must see exactly that sequence of PCs with the matching words.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        async_rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        decode_ready = 1'b0;
    logic        instr_valid_F;
    logic [31:0] instruction_F;
    logic [31:0] PC_F;
    logic [31:0] PC_plus4_F;

    fetch_stage #(
        .DATA_WIDTH (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk            (clk),
        .async_rst      (async_rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .decode_ready   (decode_ready),
        .instr_valid_F  (instr_valid_F),
        .instruction_F  (instruction_F),
        .PC_F           (PC_F),
        .PC_plus4_F     (PC_plus4_F)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Behavioural memory: pending requests in order, each with its due cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          last_due = 0;
    int          mem_lat = 1;

    // Architectural expectations.
    logic [31:0] exp_req_addr;
    logic [31:0] exp_pc;
    bit          prev_valid;
    bit          prev_fire;
    logic [31:0] prev_addr;
    int          pop_count;
    logic [31:0] first_pop_pc;
    logic [31:0] first_pop_data;
    logic [31:0] first_pop_p4;
    logic [31:0] fire_log[$];
    int          first_fire_cyc;
    int          first_valid_cyc;
    int          idle_cycles;

    // One clock cycle: drive at the falling edge, sample 1 time unit later,
    // then advance the memory and the model to what the next rising edge does.
    task automatic cycle(input bit redir, input logic [31:0] raddr,
                         input bit dready, input bit rready);
        bit    rsp;
        bit    fire;
        bit    pop;
        int    due;
        mreq_t r;
        @(negedge clk);
        cyc++;
        rsp            = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_data(mq[0].addr) : 32'hDEAD_BEEF;
        redirect_valid = redir;
        redirect_addr  = raddr;
        decode_ready   = dready;
        imem_req_ready = rready;
        #1;
        fire = imem_req_valid && imem_req_ready;
        pop  = instr_valid_F && decode_ready && !redir;

        if (redir) begin
            check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
        end else if (prev_valid && !prev_fire) begin
            check("req_valid_held", 32'(imem_req_valid), 32'd1);
            check("req_addr_held", imem_req_addr, prev_addr);
        end

        if (fire) begin
            check("req_addr", imem_req_addr, exp_req_addr);
            fire_log.push_back(imem_req_addr);
            if (first_fire_cyc < 0) first_fire_cyc = cyc;
        end

        if (!instr_valid_F) begin
            check("idle_instr", instruction_F, NOP);
            check("idle_pc", PC_F, 32'h0);
            check("idle_pc4", PC_plus4_F, 32'h4);
        end else if (first_valid_cyc < 0) begin
            first_valid_cyc = cyc;
        end

        if (pop) begin
            check("dec_pc", PC_F, exp_pc);
            check("dec_instr", instruction_F, mem_data(exp_pc));
            check("dec_pc4", PC_plus4_F, exp_pc + 32'd4);
            if (pop_count == 0) begin
                first_pop_pc   = PC_F;
                first_pop_data = instruction_F;
                first_pop_p4   = PC_plus4_F;
            end
            pop_count++;
            exp_pc      = exp_pc + 32'd4;
            idle_cycles = 0;
        end else begin
            idle_cycles++;
        end

        if (rsp) void'(mq.pop_front());
        if (fire) begin
            due      = (cyc + mem_lat > last_due + 1) ? cyc + mem_lat : last_due + 1;
            r.addr   = imem_req_addr;
            r.due    = due;
            mq.push_back(r);
            last_due = due;
            exp_req_addr = exp_req_addr + 32'd4;
        end
        if (redir) begin
            exp_pc       = raddr & ~32'h3;
            exp_req_addr = raddr & ~32'h3;
        end
        prev_valid = imem_req_valid;
        prev_fire  = fire;
        prev_addr  = imem_req_addr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_valid"}, 32'(instr_valid_F), 32'd0);
        check({tag, "_instr"}, instruction_F, NOP);
        check({tag, "_pc"}, PC_F, 32'h0);
        check({tag, "_pc4"}, PC_plus4_F, 32'h4);
    endtask

    // Memory is reset together with the stage: pending responses vanish.
    task automatic do_reset();
        async_rst      = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        decode_ready   = 1'b0;
        mq.delete();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        async_rst       = 1'b0;
        last_due        = cyc;
        exp_req_addr    = RST_PC;
        exp_pc          = RST_PC;
        prev_valid      = 1'b0;
        prev_fire       = 1'b0;
        pop_count       = 0;
        first_fire_cyc  = -1;
        first_valid_cyc = -1;
        idle_cycles     = 0;
        fire_log.delete();
    endtask

    initial begin
        int          cyc0;
        bit          redir;
        logic [31:0] raddr;

        // Basic streaming, latency 1, always ready.
        mem_lat = 1;
        do_reset();
        cyc0 = cyc;
        repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("first_req_cycle", 32'(first_fire_cyc - cyc0), 32'd1);
        check("first_valid_latency", 32'(first_valid_cyc - first_fire_cyc), 32'd2);
        check("fire_log_len_ok", 32'(fire_log.size() >= 3), 32'd1);
        check("fire0", fire_log[0], 32'h0000_0000);
        check("fire1", fire_log[1], 32'h0000_0004);
        check("fire2", fire_log[2], 32'h0000_0008);
        check("first_pop_pc", first_pop_pc, 32'h0000_0000);
        check("first_pop_data", first_pop_data, mem_data(32'h0));

        // Decode stall: FIFO fills, credits run out, nothing is lost.
        repeat (10) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("stall_req_valid_low", 32'(prev_valid), 32'd0);
        pop_count = 0;
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("stall_buffered", 32'(pop_count), 32'(DEPTH));

        // Latency 3, two requests in flight, redirect to 0x100.
        mem_lat = 3;
        do_reset();
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("two_inflight", 32'(mq.size()), 32'd2);
        cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        pop_count = 0;
        for (int i = 0; i < 40 && pop_count == 0; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("redir100_pc", first_pop_pc, 32'h0000_0100);
        check("redir100_data", first_pop_data, mem_data(32'h100));

        // Redirect coinciding with a response and a pending request.
        mem_lat = 1;
        do_reset();
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("coincide_rsp_due", 32'(mq.size()), 32'd1);
        fire_log.delete();
        cycle(1'b1, 32'h0000_0040, 1'b1, 1'b1);
        check("coincide_no_fire", 32'(fire_log.size()), 32'd0);
        pop_count = 0;
        for (int i = 0; i < 40 && pop_count == 0; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("coincide_pc", first_pop_pc, 32'h0000_0040);

        // Redirect to a misaligned address at the top of the address space.
        cycle(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        fire_log.delete();
        pop_count = 0;
        repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("wrap_fire0", fire_log[0], 32'hFFFF_FFFC);
        check("wrap_fire1", fire_log[1], 32'h0000_0000);
        check("wrap_pop_pc", first_pop_pc, 32'hFFFF_FFFC);
        check("wrap_pop_pc4", first_pop_p4, 32'h0000_0000);

        // Asynchronous reset with a full FIFO.
        repeat (10) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("full_before_reset", 32'(instr_valid_F), 32'd1);
        @(negedge clk);
        async_rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        do_reset();
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("restart_pc", fire_log[0], RST_PC);

        // Randomised traffic against the architectural model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 5) mem_lat = $urandom_range(1, 4);
            redir = ($urandom_range(0, 99) < 3);
            raddr = $urandom;
            cycle(redir, raddr, ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 70));
            if (idle_cycles > 300) begin
                check("progress", 32'(idle_cycles), 32'd0);
                break;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_stage
